fetch_stage: RTL and testbench

Instruction-fetch stage. It sits directly upstream of the decode stage and owns the PC, a single-outstanding-request instruction-memory port and the IF/ID pipeline register (`valid_o`, `pc_o`, `instruction_o`) that decode consumes. It honours decode's `stall_o` through a one-entry hold buffer. On a branch or jump redirect it restarts at the target PC and discards any in-flight or buffered fetch.

---
 rtl/params_pkg.sv | 17 +
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared widths, boot address and fetch-stage types
package params_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam logic [31:0] BOOT_ADDR = 32'h0000_1000;

    typedef logic [DATA_WIDTH-1:0] instruction_t;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, single-outstanding imem port, hold buffer, IF/ID register
module fetch_stage #(
    parameter int                    ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int                    DATA_WIDTH = params_pkg::DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = params_pkg::BOOT_ADDR
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,
    output logic                     imem_req_o,
    output logic [ADDR_WIDTH-1:0]    imem_addr_o,
    input  logic                     imem_ready_i,
    input  logic                     imem_rsp_valid_i,
    input  logic [DATA_WIDTH-1:0]    imem_rsp_data_i,
    output logic                     valid_o,
    output logic [ADDR_WIDTH-1:0]    pc_o,
    output params_pkg::instruction_t instruction_o
);
    import params_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic [ADDR_WIDTH-1:0] hold_pc;
    instruction_t          hold_data;
    logic                  slot_free;
    logic                  in_flight;
    logic [ADDR_WIDTH-1:0] redirect_target;

    // Request side depends on registered state only, keeping stall/redirect off the memory path.
    assign imem_req_o  = (state == REQ);
    assign imem_addr_o = fetch_pc;

    assign slot_free       = !valid_o || !stall_i;
    assign redirect_target = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};

    // A request is still outstanding after this edge if it was just accepted or its response is yet to come.
    assign in_flight = (((state == WAIT) || (state == DRAIN)) && !imem_rsp_valid_i)
                    || ((state == REQ) && imem_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= REQ;
            fetch_pc      <= BOOT_ADDR;
            req_pc        <= '0;
            hold_pc       <= '0;
            hold_data     <= '0;
            valid_o       <= 1'b0;
            pc_o          <= '0;
            instruction_o <= '0;
        end else if (redirect_i) begin
            valid_o   <= 1'b0;
            fetch_pc  <= redirect_target;
            hold_pc   <= '0;
            hold_data <= '0;
            state     <= in_flight ? DRAIN : REQ;
        end else begin
            // Decode consumes the current entry; a load below overrides this.
            if (valid_o && !stall_i) begin
                valid_o <= 1'b0;
            end
            case (state)
                REQ: begin
                    if (imem_ready_i) begin
                        req_pc <= fetch_pc;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid_i) begin
                        fetch_pc <= req_pc + PC_STEP;
                        if (slot_free) begin
                            valid_o       <= 1'b1;
                            pc_o          <= req_pc;
                            instruction_o <= instruction_t'(imem_rsp_data_i);
                            state         <= REQ;
                        end else begin
                            hold_pc   <= req_pc;
                            hold_data <= instruction_t'(imem_rsp_data_i);
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        valid_o       <= 1'b1;
                        pc_o          <= hold_pc;
                        instruction_o <= hold_data;
                        state         <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid_i) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with a behavioural instruction memory
module tb_fetch_stage;
    import params_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         stall_i;
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         imem_req_o;
    logic [31:0]  imem_addr_o;
    logic         imem_ready_i;
    logic         imem_rsp_valid_i;
    logic [31:0]  imem_rsp_data_i;
    logic         valid_o;
    logic [31:0]  pc_o;
    instruction_t instruction_o;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .stall_i          (stall_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ready_i     (imem_ready_i),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .valid_o          (valid_o),
        .pc_o             (pc_o),
        .instruction_o    (instruction_o)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb[$];
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          mem_lat;
    int          ready_wait;
    bit          rnd_mode;
    logic [31:0] exp_next;
    logic        prev_stuck;
    logic [31:0] prev_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return 32'h0050_0093 + (a - 32'h0000_1000);
    endfunction

    // Called at a falling edge: drives inputs, predicts the coming rising edge, then waits for the next falling edge.
    task automatic tick(input logic st, input logic rd, input logic [31:0] rpc);
        logic [63:0] e;
        logic        hs;
        stall_i       = st;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        if (pend) chk("single_outstanding", 32'(imem_req_o), 32'd0);
        if (prev_stuck) chk("addr_stable", imem_addr_o, prev_addr);
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
        if (pend) begin
            if (pend_cnt == 0) begin
                imem_rsp_valid_i = 1'b1;
                imem_rsp_data_i  = data_of(pend_addr);
                pend             = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        imem_ready_i = rnd_mode ? 1'($urandom_range(0, 1)) : (ready_wait == 0);
        hs         = imem_req_o && imem_ready_i;
        prev_stuck = imem_req_o && !imem_ready_i && !rd;
        prev_addr  = imem_addr_o;
        if (imem_req_o && !imem_ready_i && ready_wait > 0) ready_wait--;
        if (valid_o && !st && !rd) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 32'(valid_o), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("if_id_pc", pc_o, e[63:32]);
                chk("if_id_insn", instruction_o, e[31:0]);
            end
        end
        if (hs) begin
            chk("req_addr", imem_addr_o, exp_next);
            sb.push_back({exp_next, data_of(exp_next)});
            pend      = 1'b1;
            pend_addr = imem_addr_o;
            pend_cnt  = (rnd_mode ? int'($urandom_range(1, 3)) : mem_lat) - 1;
            exp_next  = exp_next + 32'd4;
        end
        if (rd) begin
            sb.delete();
            exp_next = {rpc[31:2], 2'b00};
        end
        @(negedge clk);
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        imem_ready_i = 1'b1; imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0;
        pend = 1'b0; pend_addr = '0; pend_cnt = 0; mem_lat = 1; ready_wait = 0;
        rnd_mode = 1'b0; exp_next = 32'h1000; prev_stuck = 1'b0; prev_addr = '0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_insn", instruction_o, 32'd0);
        chk("rst_req", 32'(imem_req_o), 32'd1);
        chk("rst_addr", imem_addr_o, 32'h1000);

        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("lat_valid", 32'(valid_o), 32'd1);
        chk("lat_pc", pc_o, 32'h1000);
        chk("lat_insn", instruction_o, 32'h0050_0093);
        chk("lat_next_addr", imem_addr_o, 32'h1004);
        tick(0, 0, 0);
        tick(0, 0, 0);

        // Stall across the arrival of 0x1008 forces the hold buffer.
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("hold_pc_kept", pc_o, 32'h1004);
        chk("hold_no_req", 32'(imem_req_o), 32'd0);
        tick(1, 0, 0);
        chk("hold_pc_kept2", pc_o, 32'h1004);
        chk("hold_no_req2", 32'(imem_req_o), 32'd0);
        tick(0, 0, 0);
        chk("hold_release_pc", pc_o, 32'h1008);
        chk("hold_release_valid", 32'(valid_o), 32'd1);

        mem_lat = 3;
        tick(0, 0, 0);
        tick(0, 1, 32'h2003);
        chk("redir_wait_valid", 32'(valid_o), 32'd0);
        chk("redir_wait_drain", 32'(imem_req_o), 32'd0);
        tick(0, 0, 0);
        chk("drain_no_req", 32'(imem_req_o), 32'd0);
        tick(0, 0, 0);
        chk("drain_done_addr", imem_addr_o, 32'h2000);
        mem_lat = 1;
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("redir_first_pc", pc_o, 32'h2000);

        // Redirect coinciding with a response: straight back to REQ.
        tick(0, 0, 0);
        tick(0, 1, 32'h3000);
        chk("redir_rsp_valid", 32'(valid_o), 32'd0);
        chk("redir_rsp_req", 32'(imem_req_o), 32'd1);
        chk("redir_rsp_addr", imem_addr_o, 32'h3000);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("redir_rsp_pc", pc_o, 32'h3000);

        // Redirect coinciding with a request handshake: must drain it.
        tick(0, 1, 32'h4000);
        chk("redir_hs_valid", 32'(valid_o), 32'd0);
        chk("redir_hs_drain", 32'(imem_req_o), 32'd0);
        tick(0, 0, 0);
        chk("redir_hs_addr", imem_addr_o, 32'h4000);
        chk("redir_hs_no_old", 32'(valid_o), 32'd0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("redir_hs_pc", pc_o, 32'h4000);

        ready_wait = 1;
        tick(0, 1, 32'hFFFF_FFFE);
        ready_wait = 4;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0);
            chk("wrap_addr_held", imem_addr_o, 32'hFFFF_FFFC);
        end
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
        chk("wrap_next_addr", imem_addr_o, 32'h0000_0000);

        // Async reset between edges while WAIT holds an outstanding fetch.
        mem_lat = 3;
        tick(1, 0, 0);
        chk("pre_rst_valid", 32'(valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_valid", 32'(valid_o), 32'd0);
        chk("async_rst_pc", pc_o, 32'd0);
        chk("async_rst_insn", instruction_o, 32'd0);
        chk("async_rst_addr", imem_addr_o, 32'h1000);
        pend = 1'b0; sb.delete(); exp_next = 32'h1000; prev_stuck = 1'b0; mem_lat = 1;
        @(negedge clk);
        rst_i = 1'b0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("post_rst_pc", pc_o, 32'h1000);

        rnd_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom);
        end
        rnd_mode = 1'b0;
        for (int i = 0; i < 12; i++) tick(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
